// File: rtl/uart_rx.sv
// +----------------------------------------------------------------------------+
// | uart_rx : 16x-oversampled UART receiver, start/data/parity/stop framing      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx #(
  parameter int NB_DATA         = 8,
  parameter int N_DATA          = 8,
  parameter int PARITY_CHECK    = 0,
  parameter int EVEN_ODD_PARITY = 1,
  parameter int M_STOP          = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_parity_error,
  output logic               o_frame_error
);

  localparam int c_MAX_CNT = (N_DATA > M_STOP) ? N_DATA : M_STOP;
  localparam int c_NB_CNT  = $clog2(c_MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               r_state,      w_state_next;
  logic                 r_rx_meta,    r_rx_s;
  logic [3:0]           r_tick,       w_tick_next;
  logic [c_NB_CNT-1:0]  r_bit_cnt,    w_bit_cnt_next;
  logic [N_DATA-1:0]    r_shift,      w_shift_next;
  logic                 r_par_bit,    w_par_bit_next;
  logic                 r_frame_acc,  w_frame_acc_next;
  logic [NB_DATA-1:0]   r_data,       w_data_next;
  logic                 r_done,       w_done_next;
  logic                 r_perr,       w_perr_next;
  logic                 r_ferr,       w_ferr_next;

  logic                 w_sample;
  logic                 w_stop_err;
  logic                 w_exp_par;
  logic [N_DATA:0]      w_shift_in;
  logic [NB_DATA-1:0]   w_data_ext;

  assign w_sample   = i_valid && (r_tick == 4'd15);
  assign w_stop_err = r_frame_acc | ~r_rx_s;
  assign w_exp_par  = (EVEN_ODD_PARITY != 0) ? ^r_shift : ~^r_shift;
  // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
  assign w_shift_in = {r_rx_s, r_shift};

  always_comb begin
    w_data_ext                = '0;
    w_data_ext[N_DATA-1:0]    = r_shift;
  end

  always_comb begin
    w_state_next     = r_state;
    w_tick_next      = r_tick;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_par_bit_next   = r_par_bit;
    w_frame_acc_next = r_frame_acc;
    w_data_next      = r_data;
    w_done_next      = 1'b0;
    w_perr_next      = r_perr;
    w_ferr_next      = r_ferr;

    case (r_state)
      IDLE: begin
        if (i_valid && !r_rx_s) begin
          w_tick_next  = 4'd0;
          w_state_next = START;
        end
      end

      START: begin
        if (i_valid) begin
          if (r_tick == 4'd7) begin
            w_tick_next    = 4'd0;
            w_bit_cnt_next = '0;
            w_state_next   = r_rx_s ? IDLE : DATA;
          end else begin
            w_tick_next = r_tick + 4'd1;
          end
        end
      end

      DATA: begin
        if (i_valid) begin
          w_tick_next = r_tick + 4'd1;
        end
        if (w_sample) begin
          w_shift_next = w_shift_in[N_DATA:1];
          if (r_bit_cnt == c_NB_CNT'(N_DATA - 1)) begin
            w_bit_cnt_next   = '0;
            w_frame_acc_next = 1'b0;
            w_state_next     = (PARITY_CHECK != 0) ? PARITY : STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end

      PARITY: begin
        if (i_valid) begin
          w_tick_next = r_tick + 4'd1;
        end
        if (w_sample) begin
          w_par_bit_next   = r_rx_s;
          w_bit_cnt_next   = '0;
          w_frame_acc_next = 1'b0;
          w_state_next     = STOP;
        end
      end

      STOP: begin
        if (i_valid) begin
          w_tick_next = r_tick + 4'd1;
        end
        if (w_sample) begin
          // Leaving at mid-stop lets a back-to-back start edge be seen at once.
          if (r_bit_cnt == c_NB_CNT'(M_STOP - 1)) begin
            w_state_next   = IDLE;
            w_bit_cnt_next = '0;
            w_done_next    = 1'b1;
            w_data_next    = w_data_ext;
            w_perr_next    = (PARITY_CHECK != 0) && (r_par_bit != w_exp_par);
            w_ferr_next    = w_stop_err;
          end else begin
            w_bit_cnt_next   = r_bit_cnt + 1'b1;
            w_frame_acc_next = w_stop_err;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= IDLE;
      r_tick      <= 4'd0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_frame_acc <= 1'b0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_next;
      r_tick      <= w_tick_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_par_bit   <= w_par_bit_next;
      r_frame_acc <= w_frame_acc_next;
      r_data      <= w_data_next;
      r_done      <= w_done_next;
      r_perr      <= w_perr_next;
      r_ferr      <= w_ferr_next;
    end
  end

  assign o_data         = r_data;
  assign o_rx_done      = r_done;
  assign o_parity_error = r_perr;
  assign o_frame_error  = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx : directed frames into three receiver configurations            |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b1;
  logic       rx    [3];
  logic [7:0] dout  [3];
  logic       done  [3];
  logic       perr  [3];
  logic       ferr  [3];

  int total = 0;
  int bad   = 0;
  int vdiv  = 1;
  int vcnt  = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [1:0] k;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       expq [$];
  exp_t       e_pop;
  logic [7:0] m_data    [3];
  logic       m_pe      [3];
  logic       m_fe      [3];
  logic       prev_done [3];
  int         npulse    [3];

  // 0: 8N1 default, 1: even parity, 2: two stop bits
  uart_rx u_def (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx(rx[0]), .i_valid(i_valid),
    .o_data(dout[0]), .o_rx_done(done[0]), .o_parity_error(perr[0]), .o_frame_error(ferr[0])
  );

  uart_rx #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(1)) u_par (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx(rx[1]), .i_valid(i_valid),
    .o_data(dout[1]), .o_rx_done(done[1]), .o_parity_error(perr[1]), .o_frame_error(ferr[1])
  );

  uart_rx #(.M_STOP(2)) u_stop2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx(rx[2]), .i_valid(i_valid),
    .o_data(dout[2]), .o_rx_done(done[2]), .o_parity_error(perr[2]), .o_frame_error(ferr[2])
  );

  always #5 i_clock = ~i_clock;

  always @(negedge i_clock) begin
    if (vcnt + 1 >= vdiv) vcnt = 0;
    else vcnt = vcnt + 1;
    i_valid = (vcnt == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Output model: registers clear on reset, load from the scoreboard on each done.
  always @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < 3; k++) begin
        m_data[k]    = 8'h00;
        m_pe[k]      = 1'b0;
        m_fe[k]      = 1'b0;
        prev_done[k] = 1'b0;
      end
    end
  end

  always @(negedge i_clock) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        if (done[k] === 1'b1) begin
          npulse[k]++;
          check("done_width", {31'd0, prev_done[k]}, 32'd0);
          if (expq.size() == 0 || expq[0].k != k[1:0]) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: dut=%0d got done=1 want 0 at %0t", k, $time);
          end else begin
            e_pop     = expq.pop_front();
            m_data[k] = e_pop.d;
            m_pe[k]   = e_pop.pe;
            m_fe[k]   = e_pop.fe;
          end
        end
        check("data",         {24'd0, dout[k]}, {24'd0, m_data[k]});
        check("parity_error", {31'd0, perr[k]}, {31'd0, m_pe[k]});
        check("frame_error",  {31'd0, ferr[k]}, {31'd0, m_fe[k]});
        prev_done[k] = done[k];
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clock);
      while (i_valid !== 1'b1) @(posedge i_clock);
    end
    #1;
  endtask

  task automatic idle(input int k, input int nbits);
    rx[k] = 1'b1;
    tick(16 * nbits);
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic pbit, input logic stop_low,
                      input int pc, input int even, input int nstop);
    exp_t e;
    e.k  = k[1:0];
    e.d  = d;
    e.pe = (pc != 0) ? (pbit != ((even != 0) ? ^d : ~^d)) : 1'b0;
    e.fe = stop_low;
    expq.push_back(e);
    rx[k] = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx[k] = d[i];
      tick(16);
    end
    if (pc != 0) begin
      rx[k] = pbit;
      tick(16);
    end
    for (int s = 0; s < nstop; s++) begin
      rx[k] = ~stop_low;
      tick(16);
    end
    rx[k] = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 4000) begin
      @(posedge i_clock);
      t++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", expq.size());
      expq.delete();
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx[k]     = 1'b1;
      npulse[k] = 0;
    end
    i_reset = 1'b1;
    repeat (4) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    chk_en  = 1'b1;
    check("rst_data",  {24'd0, dout[0]}, 32'h00);
    check("rst_done",  {31'd0, done[0]}, 32'd0);
    check("rst_perr",  {31'd0, perr[1]}, 32'd0);
    check("rst_ferr",  {31'd0, ferr[0]}, 32'd0);

    // 0x55, 8N1
    idle(0, 1);
    send(0, 8'h55, 1'b0, 1'b0, 0, 1, 1);
    idle(0, 2);
    drain();
    check("t1_data",   {24'd0, dout[0]}, 32'h55);
    check("t1_pulses", npulse[0], 32'd1);
    check("t1_ferr",   {31'd0, ferr[0]}, 32'd0);

    // 0xA3 even parity: popcount 4 -> correct parity bit is 0
    send(1, 8'hA3, 1'b0, 1'b0, 1, 1, 1);
    idle(1, 2);
    drain();
    check("t2_data",   {24'd0, dout[1]}, 32'hA3);
    check("t2_perr0",  {31'd0, perr[1]}, 32'd0);
    send(1, 8'hA3, 1'b1, 1'b0, 1, 1, 1);
    idle(1, 2);
    drain();
    check("t2_perr1",  {31'd0, perr[1]}, 32'd1);
    check("t2_pulses", npulse[1], 32'd2);

    // 0x3C with low stop bit, then clean 0x81
    send(0, 8'h3C, 1'b0, 1'b1, 0, 1, 1);
    idle(0, 2);
    drain();
    check("t3_data",   {24'd0, dout[0]}, 32'h3C);
    check("t3_ferr1",  {31'd0, ferr[0]}, 32'd1);
    send(0, 8'h81, 1'b0, 1'b0, 0, 1, 1);
    idle(0, 2);
    drain();
    check("t3_ferr0",  {31'd0, ferr[0]}, 32'd0);
    check("t3_data2",  {24'd0, dout[0]}, 32'h81);

    // 4-tick glitch is rejected, then 0x0F
    rx[0] = 1'b0;
    tick(4);
    idle(0, 3);
    check("t4_noglitch", npulse[0], 32'd3);
    send(0, 8'h0F, 1'b0, 1'b0, 0, 1, 1);
    idle(0, 2);
    drain();
    check("t4_data",   {24'd0, dout[0]}, 32'h0F);
    check("t4_pulses", npulse[0], 32'd4);

    // Sparse ticks, two stop bits, back-to-back 0xFF / 0x00
    vdiv = 4;
    idle(2, 1);
    send(2, 8'hFF, 1'b0, 1'b0, 0, 1, 2);
    send(2, 8'h00, 1'b0, 1'b0, 0, 1, 2);
    idle(2, 2);
    drain();
    check("t5_data",   {24'd0, dout[2]}, 32'h00);
    check("t5_pulses", npulse[2], 32'd2);
    check("t5_ferr",   {31'd0, ferr[2]}, 32'd0);
    vdiv = 1;
    idle(0, 1);

    // Reset in bit 3 of 0x96, then 0x69
    rx[0] = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx[0] = (8'h96 >> i) & 8'h01;
      tick(16);
    end
    rx[0] = 1'b0;
    tick(8);
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    rx[0]   = 1'b1;
    #1;
    check("t6_rst_data", {24'd0, dout[0]}, 32'h00);
    idle(0, 3);
    check("t6_abort",  npulse[0], 32'd4);
    send(0, 8'h69, 1'b0, 1'b0, 0, 1, 1);
    idle(0, 2);
    drain();
    check("t6_data",   {24'd0, dout[0]}, 32'h69);
    check("t6_pulses", npulse[0], 32'd5);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
